// File: rtl/imm_gen_stage.sv
// imm_gen_stage: LC-3b immediate generator with valid/ready handshake.
// Decodes the opcode of a 16-bit instruction, extracts and extends its
// immediate/offset field to WIDTH bits, and carries a sideband tag along.
// Build option: define IMM_GEN_SKID_EN for a two-entry skid buffer with a
// registered in_ready; otherwise a single output register is used.
module imm_gen_stage #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_ir,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_imm,
  output logic             out_imm_valid,
  output logic [3:0]       out_opcode,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_STB = 4'h3;
  localparam logic [3:0] OP_JSR = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_STI = 4'hB;
  localparam logic [3:0] OP_SHF = 4'hD;
  localparam logic [3:0] OP_LEA = 4'hE;
  localparam logic [3:0] OP_TRP = 4'hF;

  // Every field fits in 12 bits once shifted; zero-extended fields are
  // prepared with a clear top bit so one sign-extension covers all cases.
  function automatic logic [WIDTH-1:0] ext12(input logic signed [11:0] f);
    return {{(WIDTH-12){f[11]}}, f};
  endfunction

  logic signed [11:0] dec_field;
  logic               dec_iv;
  logic [WIDTH-1:0]   dec_imm;
  logic               accept;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_imm_q, out_imm_d;
  logic             out_iv_q, out_iv_d;
  logic [3:0]       out_op_q, out_op_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
`ifdef IMM_GEN_SKID_EN
  logic             skid_full_q, skid_full_d;
  logic [WIDTH-1:0] skid_imm_q, skid_imm_d;
  logic             skid_iv_q, skid_iv_d;
  logic [3:0]       skid_op_q, skid_op_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  assign in_ready = rst_n && !skid_full_q;
`else
  assign in_ready = rst_n && (!out_valid_q || out_ready);
`endif

  assign accept  = in_valid && in_ready;
  assign dec_imm = ext12(dec_field);

  // Per-opcode field extraction; word offsets are shifted before extension.
  always_comb begin
    dec_field = '0;
    dec_iv    = 1'b1;
    case (in_ir[15:12])
      OP_ADD, OP_AND: begin
        if (in_ir[5]) dec_field = {{7{in_ir[4]}}, in_ir[4:0]};
        else          dec_iv    = 1'b0;
      end
      OP_BR, OP_LEA:  dec_field = {{2{in_ir[8]}}, in_ir[8:0], 1'b0};
      OP_JSR: begin
        if (in_ir[11]) dec_field = {in_ir[10:0], 1'b0};
        else           dec_iv    = 1'b0;
      end
      OP_LDB, OP_STB: dec_field = {{6{in_ir[5]}}, in_ir[5:0]};
      OP_LDR, OP_STR, OP_LDI, OP_STI:
                      dec_field = {{5{in_ir[5]}}, in_ir[5:0], 1'b0};
      OP_SHF:         dec_field = {8'h00, in_ir[3:0]};
      OP_TRP:         dec_field = {3'b000, in_ir[7:0], 1'b0};
      default:        dec_iv    = 1'b0;
    endcase
  end

  // Next-state for the output register (and skid register when present).
  always_comb begin
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_iv_d    = out_iv_q;
    out_op_d    = out_op_q;
    out_tag_d   = out_tag_q;
`ifdef IMM_GEN_SKID_EN
    skid_full_d = skid_full_q;
    skid_imm_d  = skid_imm_q;
    skid_iv_d   = skid_iv_q;
    skid_op_d   = skid_op_q;
    skid_tag_d  = skid_tag_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot frees up: the older skid entry has precedence.
      if (skid_full_q) begin
        out_valid_d = 1'b1;
        out_imm_d   = skid_imm_q;
        out_iv_d    = skid_iv_q;
        out_op_d    = skid_op_q;
        out_tag_d   = skid_tag_q;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_iv_d    = dec_iv;
        out_op_d    = in_ir[15:12];
        out_tag_d   = in_tag;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Stalled with a free skid slot: park the new entry behind the head.
      skid_full_d = 1'b1;
      skid_imm_d  = dec_imm;
      skid_iv_d   = dec_iv;
      skid_op_d   = in_ir[15:12];
      skid_tag_d  = in_tag;
    end
`else
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_imm_d   = dec_imm;
      out_iv_d    = dec_iv;
      out_op_d    = in_ir[15:12];
      out_tag_d   = in_tag;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
`endif
  end

  // State registers; reset clears both control and presented data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_iv_q    <= 1'b0;
      out_op_q    <= '0;
      out_tag_q   <= '0;
`ifdef IMM_GEN_SKID_EN
      skid_full_q <= 1'b0;
      skid_imm_q  <= '0;
      skid_iv_q   <= 1'b0;
      skid_op_q   <= '0;
      skid_tag_q  <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_iv_q    <= out_iv_d;
      out_op_q    <= out_op_d;
      out_tag_q   <= out_tag_d;
`ifdef IMM_GEN_SKID_EN
      skid_full_q <= skid_full_d;
      skid_imm_q  <= skid_imm_d;
      skid_iv_q   <= skid_iv_d;
      skid_op_q   <= skid_op_d;
      skid_tag_q  <= skid_tag_d;
`endif
    end
  end

  assign out_valid     = out_valid_q;
  assign out_imm       = out_imm_q;
  assign out_imm_valid = out_iv_q;
  assign out_opcode    = out_op_q;
  assign out_tag       = out_tag_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Testbench for imm_gen_stage: directed and random stimulus against a
// queue-based reference model. Two instances (WIDTH=32 and WIDTH=16)
// receive identical inputs.
module tb_imm_gen_stage;

`ifdef IMM_GEN_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_ir = '0;
  logic [15:0] in_tag = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, in_ready16;
  logic        out_valid, out_valid16;
  logic [31:0] out_imm;
  logic [15:0] out_imm16;
  logic        out_imm_valid, out_imm_valid16;
  logic [3:0]  out_opcode, out_opcode16;
  logic [15:0] out_tag, out_tag16;

  always #5 clk = ~clk;

  imm_gen_stage #(.WIDTH(32), .TAG_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_imm_valid(out_imm_valid), .out_opcode(out_opcode), .out_tag(out_tag)
  );

  imm_gen_stage #(.WIDTH(16), .TAG_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready16), .in_ir(in_ir), .in_tag(in_tag),
    .out_valid(out_valid16), .out_ready(out_ready), .out_imm(out_imm16),
    .out_imm_valid(out_imm_valid16), .out_opcode(out_opcode16), .out_tag(out_tag16)
  );

  typedef struct {
    longint      imm;
    bit          iv;
    int          op;
    logic [15:0] tag;
  } ent_t;

  ent_t q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Signed value of an n-bit two's-complement field.
  function automatic longint sx(input longint f, input int n);
    longint half = longint'(1) << (n - 1);
    return (f >= half) ? f - (half * 2) : f;
  endfunction

  function automatic ent_t ref_ent(input logic [15:0] ir, input logic [15:0] tg);
    ent_t e;
    e.op = int'(ir[15:12]);
    e.tag = tg;
    e.iv = 1'b1;
    e.imm = 0;
    case (e.op)
      1, 5:         if (ir[5]) e.imm = sx(longint'(ir[4:0]), 5); else e.iv = 1'b0;
      0, 14:        e.imm = sx(longint'(ir[8:0]), 9) * 2;
      4:            if (ir[11]) e.imm = sx(longint'(ir[10:0]), 11) * 2; else e.iv = 1'b0;
      2, 3:         e.imm = sx(longint'(ir[5:0]), 6);
      6, 7, 10, 11: e.imm = sx(longint'(ir[5:0]), 6) * 2;
      13:           e.imm = longint'(ir[3:0]);
      15:           e.imm = longint'(ir[7:0]) * 2;
      default:      e.iv = 1'b0;
    endcase
    if (!e.iv) e.imm = 0;
    return e;
  endfunction

  // One clock cycle: drive at negedge, check in_ready, update model at the
  // posedge, check outputs at the following negedge.
  task automatic cycle(input logic v, input logic [15:0] ir, input logic [15:0] tg,
                       input logic ordy, input logic fl, input logic rn, output bit acc);
    bit exp_rdy, fire;
    longint m;
    logic [31:0] e32;
    in_valid = v; in_ir = ir; in_tag = tg; out_ready = ordy; flush = fl; rst_n = rn;
    #1;
    if (CAP == 2) exp_rdy = rn && (q.size() < 2);
    else          exp_rdy = rn && (q.size() == 0 || ordy);
    chk_val("in_ready", in_ready, exp_rdy);
    chk_val("in_ready16", in_ready16, exp_rdy);
    acc  = v && exp_rdy && !fl;
    fire = (q.size() > 0) && ordy;
    @(posedge clk);
    if (!rn || fl) q.delete();
    else begin
      if (fire) void'(q.pop_front());
      if (v && exp_rdy) q.push_back(ref_ent(ir, tg));
    end
    @(negedge clk);
    chk_val("out_valid", out_valid, q.size() > 0);
    chk_val("out_valid16", out_valid16, q.size() > 0);
    if (q.size() > 0) begin
      m = q[0].imm;
      e32 = m[31:0];
      chk_val("out_imm", out_imm, e32);
      chk_val("out_imm16", out_imm16, e32[15:0]);
      chk_val("out_imm_valid", out_imm_valid, q[0].iv);
      chk_val("out_opcode", out_opcode, q[0].op);
      chk_val("out_tag", out_tag, q[0].tag);
      chk_val("out_tag16", out_tag16, q[0].tag);
    end else if (!rn) begin
      chk_val("rst_imm", out_imm, 0);
      chk_val("rst_imm16", out_imm16, 0);
      chk_val("rst_imm_valid", out_imm_valid, 0);
      chk_val("rst_opcode", out_opcode, 0);
      chk_val("rst_tag", out_tag, 0);
    end
  endtask

  logic [15:0] dir_ir [8] = '{16'h127D, 16'h0FFF, 16'h6820, 16'hF025,
                              16'hD03F, 16'h4080, 16'h1042, 16'h5FE1};
  logic [15:0] stall_ir [4] = '{16'h0FFF, 16'h6820, 16'hF025, 16'hD03F};

  initial begin
    bit a;
    int k;
    int drained;
    @(negedge clk);
    // Reset
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, a);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, a);

    // Directed decode vectors, streamed back to back
    for (int i = 0; i < 8; i++) cycle(1'b1, dir_ir[i], 16'h100 + 16'(i), 1'b1, 1'b0, 1'b1, a);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, a);

    // Stall with four pending instructions, then drain
    k = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(k < 4, stall_ir[k < 4 ? k : 0], 16'(k), c == 0, 1'b0, 1'b1, a);
      if (a) k++;
    end
    chk_val("stall_accepted", k, CAP);
    drained = 0;
    for (int c = 0; c < 20 && drained == 0; c++) begin
      cycle(k < 4, stall_ir[k < 4 ? k : 0], 16'(k), 1'b1, 1'b0, 1'b1, a);
      if (a) k++;
      if (k == 4 && q.size() == 0) drained = 1;
    end
    chk_val("stall_drained", drained, 1);

    // Fill to capacity, then flush with a simultaneous input
    for (int c = 0; c < 3; c++) cycle(1'b1, 16'h2A05 + 16'(c), 16'h200 + 16'(c), 1'b0, 1'b0, 1'b1, a);
    cycle(1'b1, 16'hE1FF, 16'hDEAD, 1'b0, 1'b1, 1'b1, a);
    chk_val("flush_out_valid", out_valid, 0);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, a);

    // Fill to capacity, then reset for one cycle
    for (int c = 0; c < 3; c++) cycle(1'b1, 16'h7FC1 + 16'(c), 16'h300 + 16'(c), 1'b0, 1'b0, 1'b1, a);
    cycle(1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 1'b0, a);
    chk_val("reset_out_valid", out_valid, 0);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, a);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 99) != 0), a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Pipelined, parametrised immediate generator for the LC-3b decode path. It takes a full 16-bit instruction word, decodes the opcode, and extracts the immediate or offset field. It sign- or zero-extends that field to WIDTH bits, applying the ×2 word shift where the ISA requires it. It sits between fetch/IR and the decode/execute register and passes a sideband tag (normally the PC) through with each result behind a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 16, output immediate width; legal values ≥16.
- TAG_W, 16, width of the sideband tag carried with each instruction.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  in_ir/in_tag valid.
- in_ready  out  1  stage accepts input this cycle.
- in_ir  in  16  instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  out_* valid.
- out_ready  in  1  consumer accepts output this cycle.
- out_imm  out  WIDTH  extended immediate.
- out_imm_valid  out  1  instruction carries an immediate.
- out_opcode  out  4  in_ir[15:12] of the presented entry.
- out_tag  out  TAG_W  tag of the presented entry.

## Operation
- Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- Decode is per opcode; "sext" extends to WIDTH bits, and the shift is applied before extension:
  - ADD 0001 / AND 0101: if ir[5]=1, sext(ir[4:0]) with imm_valid=1; otherwise imm=0 and imm_valid=0.
  - BR 0000 / LEA 1110: sext({ir[8:0],0}).
  - JSR 0100: if ir[11]=1, sext({ir[10:0],0}); otherwise (JSRR) imm=0 and imm_valid=0.
  - LDB 0010 / STB 0011: sext(ir[5:0]).
  - LDR 0110 / STR 0111 / LDI 1010 / STI 1011: sext({ir[5:0],0}).
  - SHF 1101: zext(ir[3:0]); the shift amount is unsigned.
  - TRAP 1111: zext({ir[7:0],0}).
  - NOT 1001, RTI 1000, JMP 1100: imm=0 and imm_valid=0.
- out_tag and out_opcode always correspond to the entry presented on out_imm.
- Entries leave strictly in acceptance order. No entry is dropped or duplicated except by flush.
- flush: every held entry is invalidated at the edge. An input presented in the same cycle is discarded.
- Priority: rst_n low > flush > normal transfer.

## Timing
- Latency: an entry accepted at edge N appears on out_* with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one instruction per cycle while out_ready=1.
- Reset (rst_n low at an edge): out_valid=0, out_imm=0, out_imm_valid=0, out_opcode=0, out_tag=0, all internal entries empty.
- in_ready is 0 while rst_n is low. It is 1 in the first cycle after rst_n rises.
- Reset mid-stall loses every held entry. Nothing is presented until a new input is accepted.
- out_* hold stable while out_valid && !out_ready.
- After flush, out_valid=0 in the next cycle. in_ready=1 in that cycle (both entries empty).
- Simultaneous input and output transfer when full-capacity with out_ready=1: the presented entry leaves, the held entry or the new entry moves up, and nothing is lost.

## Configuration
- IMM_GEN_SKID_EN defined:
  - Two-entry skid buffer (output register plus skid register).
  - in_ready is a registered signal equal to !skid_full, with no combinational path from out_ready.
  - While stalled, the stage absorbs one extra entry, then drops in_ready.
- IMM_GEN_SKID_EN undefined:
  - Single output register.
  - in_ready = rst_n && (!out_valid || out_ready), a combinational path from out_ready.
  - Capacity is 1.
- Decode, latency, reset values and flush behaviour are identical in both builds.

## Test plan
- ADD R1,R2,#-3 (in_ir=0x127D), WIDTH=32, out_ready=1 -> next cycle out_imm=0xFFFFFFFD, imm_valid=1, opcode=1.
- BR offset -1 (0x0FFF), LDR off6=0x20 (0x6820), TRAP x25 (0xF025), SHF amt 0xF (0xD03F), WIDTH=16 -> out_imm=0xFFFE, 0xFFC0, 0x004A, 0x000F respectively, in order with tags preserved.
- JSRR (0x4080) and ADD register form (0x1042) -> out_imm=0, imm_valid=0, out_valid=1.
- Stream of 4 instructions with out_ready=0 from cycle 2:
  - Skid build: accepts 2, then in_ready=0.
  - Non-skid build: accepts 1.
  - On out_ready=1, all outputs appear in order with tags 0..3 and no gaps.
- Two entries held, flush=1 with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, flushed input never appears.
- rst_n=0 for one cycle while stalled full -> all out_* = 0 and out_valid=0 next cycle; in_ready=0 during reset, 1 after.
